vc_mem_req_arb_2port: RTL

//  Two-requester round-robin arbiter that shares one single-port test memory (with random delay).

---
 rtl/vc_mem_req_arb_2port.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/vc_mem_req_arb_2port.sv
// vc_mem_req_arb_2port
// Round-robin arbiter that lets two val/rdy requesters share one memory
// request/response port pair. The memory answers in request order, so a
// small FIFO of requester IDs (one bit per in-flight request) is enough to
// send each response back to the requester that issued it.
//
// Handshake semantics (all six channels): a transfer happens on a rising
// clk edge where val and rdy are both high. A producer holding val high
// keeps its msg stable until the transfer. rdy may depend on val; val never
// depends on rdy of the same channel.
//
// Request message layout  : {type(1), addr(p_addr_sz), len(c_len_sz), data(p_data_sz)}
// Response message layout : {type(1), len(c_len_sz), data(p_data_sz)}
module vc_mem_req_arb_2port #(
    parameter int p_addr_sz         = 8,
    parameter int p_data_sz         = 32,
    parameter int p_max_outstanding = 4,
    localparam int c_len_sz         = $clog2(p_data_sz / 8),
    localparam int c_req_msg_sz     = 1 + p_addr_sz + c_len_sz + p_data_sz,
    localparam int c_resp_msg_sz    = 1 + c_len_sz + p_data_sz,
    localparam int c_cnt_sz         = $clog2(p_max_outstanding + 1)
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     req0_val,
    output logic                     req0_rdy,
    input  logic [c_req_msg_sz-1:0]  req0_msg,

    input  logic                     req1_val,
    output logic                     req1_rdy,
    input  logic [c_req_msg_sz-1:0]  req1_msg,

    output logic                     resp0_val,
    input  logic                     resp0_rdy,
    output logic [c_resp_msg_sz-1:0] resp0_msg,

    output logic                     resp1_val,
    input  logic                     resp1_rdy,
    output logic [c_resp_msg_sz-1:0] resp1_msg,

    output logic                     memreq_val,
    input  logic                     memreq_rdy,
    output logic [c_req_msg_sz-1:0]  memreq_msg,

    input  logic                     memresp_val,
    output logic                     memresp_rdy,
    input  logic [c_resp_msg_sz-1:0] memresp_msg,

    output logic [c_cnt_sz-1:0]      num_outstanding
);

    localparam int c_ptr_sz = (p_max_outstanding > 1) ? $clog2(p_max_outstanding) : 1;
    localparam logic [c_cnt_sz-1:0] c_full_cnt = c_cnt_sz'(p_max_outstanding);
    localparam logic [c_ptr_sz-1:0] c_last_ptr = c_ptr_sz'(p_max_outstanding - 1);

    // Pointers wrap at the configured depth, which need not be a power of two.
    function automatic logic [c_ptr_sz-1:0] ptr_inc(input logic [c_ptr_sz-1:0] p);
        return (p == c_last_ptr) ? '0 : p + c_ptr_sz'(1);
    endfunction

    logic                prio_q;      // requester preferred when both are valid
    logic                id_q [p_max_outstanding];
    logic [c_ptr_sz-1:0] head_q;
    logic [c_ptr_sz-1:0] tail_q;
    logic [c_cnt_sz-1:0] count_q;

    logic grant0;
    logic grant1;
    logic full;
    logic empty;
    logic head_id;
    logic push;
    logic pop;

    // Grant selection, FIFO status and the steering of both directions.
    always_comb begin
        grant0      = req0_val & (~req1_val | ~prio_q);
        grant1      = req1_val & (~req0_val |  prio_q);
        full        = (count_q == c_full_cnt);
        empty       = (count_q == '0);
        head_id     = id_q[head_q];

        memreq_msg  = grant1 ? req1_msg : req0_msg;
        resp0_msg   = memresp_msg;
        resp1_msg   = memresp_msg;

        memreq_val  = 1'b0;
        req0_rdy    = 1'b0;
        req1_rdy    = 1'b0;
        resp0_val   = 1'b0;
        resp1_val   = 1'b0;
        memresp_rdy = 1'b0;

        // Full is judged on the registered count only, so a pop in the same
        // cycle never opens the request side (no rdy path from resp rdy).
        if (!reset) begin
            memreq_val  = (req0_val | req1_val) & ~full;
            req0_rdy    = grant0 & memreq_rdy & ~full;
            req1_rdy    = grant1 & memreq_rdy & ~full;
            resp0_val   = memresp_val & ~empty & ~head_id;
            resp1_val   = memresp_val & ~empty &  head_id;
            memresp_rdy = ~empty & (head_id ? resp1_rdy : resp0_rdy);
        end

        push = memreq_val & memreq_rdy;
        pop  = memresp_val & memresp_rdy;
    end

    assign num_outstanding = count_q;

    // Priority flip on every issue, FIFO pointers and occupancy count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_q  <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                tail_q <= ptr_inc(tail_q);
                prio_q <= ~grant1;
            end
            if (pop) begin
                head_q <= ptr_inc(head_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + c_cnt_sz'(1);
                2'b01:   count_q <= count_q - c_cnt_sz'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ID storage; entries are only meaningful between push and pop.
    always_ff @(posedge clk) begin
        if (push) begin
            id_q[tail_q] <= grant1;
        end
    end

endmodule
